bitrev_rr_arbiter: RTL and testbench
====================================

# bitrev_rr_arbiter

Round-robin arbiter and sequencer that shares one N-bit bit-reversal datapath (out bit i = in bit N-1-i) among M requesters. Each requester offers a word on a valid/ready port. The arbiter grants one requester per accepted transfer and captures its word. It then presents the reversed word with the winner's index on a single valid/ready output. This block sits between the requesting front-ends and the downstream consumer of reordered words.

## Interface
- N, 8, data word width; N >= 2
- M, 4, number of requesters; M >= 2
- IW, $clog2(M), requester index width (derived, not overridable)
- clk  input  1  sole clock; all state changes on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- req_valid  input  M  bit k: requester k offers a word
- req_data  input  M*N  requester k word at bits [k*N +: N]
- req_ready  output  M  bit k: requester k's word is accepted this cycle; one-hot or zero
- out_valid  output  1  out_data/out_id hold a result
- out_data  output  N  bit-reversed captured word
- out_id  output  IW  index of the requester that supplied out_data
- out_ready  input  1  consumer accepts the result this cycle

## Operation
- States: IDLE (no result held) and FULL (result held, out_valid=1).
- Accept condition: acc = (state==IDLE) | (state==FULL & out_ready).
- Arbitration is combinational.
  - Winner w = first k with req_valid[k]=1, searching ptr, ptr+1, ..., M-1, 0, ..., ptr-1.
  - req_ready[w] = acc & |req_valid & rst_n. All other req_ready bits are 0.
  - req_ready never asserts for a requester whose req_valid=0.
- On a grant (any req_ready bit = 1):
  - cap <= req_data[w*N +: N]; out_id <= w.
  - ptr <= (w==M-1) ? 0 : w+1.
  - state <= FULL.
- In FULL with out_ready=1 and no grant: state <= IDLE, out_valid falls next cycle.
- In FULL with out_ready=0: cap, out_id and ptr hold; req_ready = 0.
- out_data[i] = cap[N-1-i] for all i. This is a registered-capture, combinationally reversed output.
- No grant: ptr holds.
- Reset (rst_n=0 at an edge): state=IDLE, ptr=0, cap=0, out_id=0.
  - Outputs after reset: out_valid=0, out_data=0, out_id=0, req_ready=0.
  - While rst_n=0, req_ready=0 regardless of inputs.
  - Reset mid-transfer discards the held result. There is no handshake completion for it.
- Fairness: with all M requesters continuously valid and out_ready=1, grants rotate 0,1,...,M-1,0,...
  - Any continuously-valid requester is granted within M grants.

## Timing
- Request-to-output latency: word accepted at edge t (req_ready=1 in cycle t-1 to t) → out_valid=1 from cycle after edge t.
- Throughput: one word per cycle when out_ready is held 1 and any request is valid. Back-to-back grants are allowed in FULL & out_ready.
- req_ready depends combinationally on req_valid, out_ready and state. Requesters must not make req_valid depend on req_ready.
- out_valid, out_data and out_id are registered (or derived only from registers). No combinational path from inputs.
- Once out_valid=1, out_data and out_id are stable until the cycle in which out_ready=1.
- Requester rule: once req_valid=1, data is held stable until req_ready=1. The arbiter does not check this rule.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with all req_valid=1 and out_ready=1 → req_ready=0, out_valid=0, out_data=0, out_id=0 throughout. The first grant after release goes to requester 0.
- Single transfer (N=8, M=4): requester 2 offers 8'b0000_0011 in IDLE → req_ready=4'b0100 that cycle. Next cycle out_valid=1, out_data=8'b1100_0000, out_id=2. ptr becomes 3.
- Backpressure: hold out_ready=0 for 5 cycles with results pending → out_data and out_id unchanged, req_ready=0 all 5 cycles. Raising out_ready and a new valid request → handover and new grant in the same cycle.
- Rotation: all four req_valid=1 continuously, out_ready=1 → grants 0,1,2,3,0,1 on consecutive cycles, out_id following one cycle later.
- Wrap-around and skip: ptr=3, only requesters 1 and 3 valid → grant 3 then 1. ptr ends at 2.
- Reset mid-operation: assert rst_n=0 while FULL with out_ready=0 → next cycle out_valid=0 and ptr=0. The held word is never delivered.

Source files
------------

// File: rtl/bitrev_rr_arbiter_if.sv
// bitrev_rr_arbiter_if: requester ports plus result port of the shared bit-reversal arbiter
interface bitrev_rr_arbiter_if #(
    parameter int N = 8,
    parameter int M = 4
);
    localparam int IW = $clog2(M);
    logic [M-1:0]   req_valid;
    logic [M*N-1:0] req_data;
    logic [M-1:0]   req_ready;
    logic           out_valid;
    logic [N-1:0]   out_data;
    logic [IW-1:0]  out_id;
    logic           out_ready;
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/bitrev_rr_arbiter.sv
// bitrev_rr_arbiter: round-robin grant of M requesters onto one registered bit-reversal stage
module bitrev_rr_arbiter #(
    parameter int N = 8,
    parameter int M = 4
) (
    input logic clk,
    input logic rst_n,
    bitrev_rr_arbiter_if.slave b
);
    localparam int IW = $clog2(M);
    typedef enum logic {IDLE, FULL} state_t;
    state_t state, state_n;
    logic [IW-1:0] ptr, w, j, id;
    logic [N-1:0] cap;
    logic any, acc, grant;
    assign acc = (state == IDLE) | b.out_ready;
    assign grant = acc & any & rst_n;
    assign b.req_ready = grant ? M'(1) << w : '0;
    assign b.out_valid = (state == FULL);
    assign b.out_id = id;
    // search starts at ptr and wraps, so the most recent winner is tried last
    always_comb begin
        w = '0;
        j = '0;
        any = 1'b0;
        for (int i = 0; i < M; i++) begin
            j = IW'((int'(ptr) + i) % M);
            if (!any && b.req_valid[j]) begin
                w = j;
                any = 1'b1;
            end
        end
    end
    always_comb begin
        b.out_data = '0;
        for (int i = 0; i < N; i++)
            b.out_data[i] = cap[N-1-i];
    end
    always_comb state_n = grant ? FULL : (state == FULL && b.out_ready) ? IDLE : state;
    always_ff @(posedge clk)
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            cap <= '0;
            id <= '0;
        end else begin
            state <= state_n;
            if (grant) begin
                cap <= b.req_data[w*N +: N];
                id <= w;
                ptr <= (w == IW'(M - 1)) ? '0 : w + IW'(1);
            end
        end
endmodule

// File: tb/tb_bitrev_rr_arbiter.sv
// tb_bitrev_rr_arbiter: directed grants scoreboarded against the result port by a separate monitor
module tb_bitrev_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [9:0] q[$];
    logic [7:0] rev_tab [4] = '{8'h80, 8'h48, 8'hC0, 8'h0F};
    bitrev_rr_arbiter_if #(.N(8), .M(4)) b();
    bitrev_rr_arbiter #(.N(8), .M(4)) dut (.clk(clk), .rst_n(rst_n), .b(b));
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step(input logic r, input logic [3:0] v, input logic o, input logic [3:0] er, input int eid);
        @(posedge clk);
        #1;
        rst_n = r;
        b.req_valid = v;
        b.out_ready = o;
        #1;
        chk("req_ready", int'(b.req_ready), int'(er));
        if (er != 4'b0) q.push_back({2'(eid), rev_tab[eid]});
    endtask
    initial begin
        forever begin
            @(negedge clk);
            if (b.out_valid) begin
                if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
                else begin
                    chk("out_id", int'(b.out_id), int'(q[0][9:8]));
                    chk("out_data", int'(b.out_data), int'(q[0][7:0]));
                    if (b.out_ready) void'(q.pop_front());
                end
            end
        end
    end
    initial begin
        b.req_valid = 4'hF;
        b.req_data = {8'hF0, 8'h03, 8'h12, 8'h01};
        b.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'hF, 1'b1, 4'b0000, 0);
            chk("rst_out_valid", int'(b.out_valid), 0);
            chk("rst_out_data", int'(b.out_data), 0);
            chk("rst_out_id", int'(b.out_id), 0);
        end
        step(1'b1, 4'hF, 1'b1, 4'b0001, 0);
        step(1'b1, 4'h0, 1'b1, 4'b0000, 0);
        step(1'b1, 4'b0100, 1'b1, 4'b0100, 2);
        step(1'b1, 4'h0, 1'b0, 4'b0000, 0);
        chk("single_out_valid", int'(b.out_valid), 1);
        for (int i = 0; i < 5; i++) step(1'b1, 4'hF, 1'b0, 4'b0000, 0);
        step(1'b1, 4'hF, 1'b1, 4'b1000, 3);
        step(1'b1, 4'hF, 1'b1, 4'b0001, 0);
        step(1'b1, 4'hF, 1'b1, 4'b0010, 1);
        step(1'b1, 4'hF, 1'b1, 4'b0100, 2);
        step(1'b1, 4'hF, 1'b1, 4'b1000, 3);
        step(1'b1, 4'hF, 1'b1, 4'b0001, 0);
        step(1'b1, 4'hF, 1'b1, 4'b0010, 1);
        step(1'b1, 4'b0100, 1'b1, 4'b0100, 2);
        step(1'b1, 4'b1010, 1'b1, 4'b1000, 3);
        step(1'b1, 4'b1010, 1'b1, 4'b0010, 1);
        step(1'b1, 4'hF, 1'b1, 4'b0100, 2);
        step(1'b1, 4'h0, 1'b0, 4'b0000, 0);
        step(1'b0, 4'hF, 1'b0, 4'b0000, 0);
        step(1'b1, 4'hF, 1'b1, 4'b0001, 0);
        chk("midrst_out_valid", int'(b.out_valid), 0);
        chk("midrst_queue", int'(q.size()), 2);
        if (q.size() > 0) void'(q.pop_front());
        step(1'b1, 4'h0, 1'b1, 4'b0000, 0);
        step(1'b1, 4'h0, 1'b1, 4'b0000, 0);
        step(1'b1, 4'h0, 1'b1, 4'b0000, 0);
        chk("final_out_valid", int'(b.out_valid), 0);
        chk("final_queue_empty", int'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
